// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared limits, overlap-mode constants and counter helper for seq_detect_p
package seq_detect_pkg;

  localparam int SEQ_LEN_MIN = 2;
  localparam int SEQ_LEN_MAX = 16;

  localparam logic SEQ_NO_OVERLAP = 1'b0;
  localparam logic SEQ_OVERLAP    = 1'b1;

  // Saturating increment for counters up to 31 bits wide.
  function automatic logic [31:0] seq_sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (32'h1 << width) - 32'h1;
    return (val >= max_val) ? max_val : val + 32'h1;
  endfunction

endpackage

// File: rtl/seq_detect_p_prefix.sv
// rtl/seq_detect_p_prefix.sv - longest proper pattern prefix that is a suffix of the history
module seq_prefix_len
  import seq_detect_pkg::*;
#(
  parameter int LEN    = 4,
  parameter int PROG_W = $clog2(LEN),
  parameter int FILL_W = $clog2(LEN + 1)
) (
  input  logic [LEN-1:0]    i_hist_n,
  input  logic [FILL_W-1:0] i_fill_n,
  input  logic [LEN-1:0]    i_pat,
  output logic [PROG_W-1:0] o_prefix
);

  logic [LEN-1:0] w_pat_top;
  logic [LEN-1:0] w_mask;

  // Ascending k so the last qualifying length wins, giving the maximum.
  always_comb begin
    o_prefix  = '0;
    w_pat_top = '0;
    w_mask    = '0;
    for (int k = 1; k < LEN; k++) begin
      w_pat_top = i_pat >> (LEN - k);
      w_mask    = {LEN{1'b1}} >> (LEN - k);
      if ((FILL_W'(k) <= i_fill_n) && (((i_hist_n ^ w_pat_top) & w_mask) == '0)) begin
        o_prefix = PROG_W'(k);
      end
    end
  end

endmodule

// File: rtl/seq_detect_p.sv
// rtl/seq_detect_p.sv - runtime-programmable serial pattern detector with overlap mode
// Optional saturating match counter built when SEQ_DETECT_CNT_EN is defined.
module seq_detect_p
  import seq_detect_pkg::*;
#(
  parameter int             LEN           = 4,
  parameter int             PROG_W        = $clog2(LEN),
  parameter int             CNT_W         = 8,
  parameter logic [LEN-1:0] PATTERN_RESET = 4'b1011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  input  logic              in_valid,
  input  logic              overlap,
  input  logic              cfg_load,
  input  logic [LEN-1:0]    cfg_pattern,
  output logic              match,
  output logic [PROG_W-1:0] progress,
  output logic [CNT_W-1:0]  match_count
);

  localparam int                FILL_W    = $clog2(LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);

  if (LEN < SEQ_LEN_MIN || LEN > SEQ_LEN_MAX) begin : g_bad_len
    $error("seq_detect_p: LEN out of range");
  end

  // The oldest history bit is shifted out on every accept, so only LEN-1 bits need storing.
  logic [LEN-2:0]    r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [LEN-1:0]    r_pat;
  logic              r_match;
  logic [PROG_W-1:0] r_progress;

  logic [LEN-1:0]    w_hist_n;
  logic [FILL_W-1:0] w_fill_n;
  logic              w_hit;
  logic [PROG_W-1:0] w_prefix;

  logic [LEN-2:0]    w_hist_d;
  logic [FILL_W-1:0] w_fill_d;
  logic [LEN-1:0]    w_pat_d;
  logic              w_match_d;
  logic [PROG_W-1:0] w_progress_d;

  assign w_hist_n = {r_hist, in};
  assign w_fill_n = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 1'b1;
  assign w_hit    = (w_fill_n == FILL_FULL) && (w_hist_n == r_pat);

  seq_prefix_len #(
    .LEN    (LEN),
    .PROG_W (PROG_W),
    .FILL_W (FILL_W)
  ) u_prefix (
    .i_hist_n (w_hist_n),
    .i_fill_n (w_fill_n),
    .i_pat    (r_pat),
    .o_prefix (w_prefix)
  );

  always_comb begin
    w_hist_d     = r_hist;
    w_fill_d     = r_fill;
    w_pat_d      = r_pat;
    w_match_d    = 1'b0;
    w_progress_d = r_progress;
    if (cfg_load) begin
      w_pat_d      = cfg_pattern;
      w_fill_d     = '0;
      w_progress_d = '0;
    end else if (in_valid) begin
      w_hist_d  = w_hist_n[LEN-2:0];
      w_match_d = w_hit;
      if (w_hit && overlap == SEQ_NO_OVERLAP) begin
        w_fill_d     = '0;
        w_progress_d = '0;
      end else begin
        w_fill_d     = w_fill_n;
        w_progress_d = w_prefix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist     <= '0;
      r_fill     <= '0;
      r_pat      <= PATTERN_RESET;
      r_match    <= 1'b0;
      r_progress <= '0;
    end else begin
      r_hist     <= w_hist_d;
      r_fill     <= w_fill_d;
      r_pat      <= w_pat_d;
      r_match    <= w_match_d;
      r_progress <= w_progress_d;
    end
  end

  assign match    = r_match;
  assign progress = r_progress;

`ifdef SEQ_DETECT_CNT_EN
  logic [CNT_W-1:0] r_match_count;
  logic [CNT_W-1:0] w_count_d;

  always_comb begin
    w_count_d = r_match_count;
    if (!cfg_load && in_valid && w_hit) begin
      w_count_d = CNT_W'(seq_sat_inc(32'(r_match_count), CNT_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_match_count <= '0;
    end else begin
      r_match_count <= w_count_d;
    end
  end

  assign match_count = r_match_count;
`else
  assign match_count = {CNT_W{1'b0}};
`endif

endmodule
